// File: rtl/layer_output_serializer_pkg.sv
// rtl/layer_output_serializer_pkg.sv - shared types and sizing helpers for the layer output serializer
// Code width follows LAYER_OUTPUT_SERIALIZER_DEQUANT_EN.
package layer_output_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

`ifdef LAYER_OUTPUT_SERIALIZER_DEQUANT_EN
    localparam bit DEQUANT_EN = 1'b1;
`else
    localparam bit DEQUANT_EN = 1'b0;
`endif

    function automatic int calc_nbeats(input int num_neurons, input int beat_codes);
        return (num_neurons + beat_codes - 1) / beat_codes;
    endfunction

    function automatic int calc_beat_w(input int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

    function automatic int code_width(input int out_bits, input int dq_w);
        return DEQUANT_EN ? dq_w : out_bits;
    endfunction

endpackage

// File: rtl/layer_output_serializer_code_dequant.sv
// rtl/layer_output_serializer_code_dequant.sv - per-slot code dequantizer
// Scales by SCALE when LAYER_OUTPUT_SERIALIZER_DEQUANT_EN is defined, otherwise a plain wire.
module code_dequant #(
    parameter int          OUT_BITS = 2,
    parameter int unsigned SCALE    = 3,
    parameter int          DQ_W     = 8,
    parameter int          CW       = 2
) (
    input  logic [OUT_BITS-1:0] code,
    output logic [CW-1:0]       value
);

`ifdef LAYER_OUTPUT_SERIALIZER_DEQUANT_EN
    localparam int PW = OUT_BITS + 32;
    logic [PW-1:0] prod;

    // Zero-extended code times SCALE, truncated to the dequantized width.
    assign prod  = PW'(code) * PW'(SCALE);
    assign value = CW'(prod[DQ_W-1:0]);
`else
    assign value = code;
`endif

endmodule

// File: rtl/layer_output_serializer.sv
// rtl/layer_output_serializer.sv - captures a layer output vector and streams it as fixed-width beats
// Optional dequantization via LAYER_OUTPUT_SERIALIZER_DEQUANT_EN.
module layer_output_serializer
    import layer_output_serializer_pkg::*;
#(
    parameter int          NUM_NEURONS = 16,
    parameter int          OUT_BITS    = 2,
    parameter int          BEAT_CODES  = 4,
    parameter int unsigned SCALE       = 3,
    parameter int          DQ_W        = 8,
    localparam int         CW          = code_width(OUT_BITS, DQ_W)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_NEURONS*OUT_BITS-1:0] in_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [BEAT_CODES*CW-1:0]      m_data,
    output logic                          m_last
);

    localparam int NBEATS = calc_nbeats(NUM_NEURONS, BEAT_CODES);
    localparam int BW     = calc_beat_w(NBEATS);
    localparam int WORD_W = BEAT_CODES * OUT_BITS;
    localparam int IN_W   = NUM_NEURONS * OUT_BITS;
    localparam int PAD_W  = NBEATS * WORD_W;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    ser_state_t                state, state_n;
    logic [BW-1:0]             beat, beat_n;
    logic [IN_W-1:0]           cap;
    logic                      capture;
    logic [PAD_W-1:0]          padded;
    logic [WORD_W-1:0]         beat_words [NBEATS];
    logic [WORD_W-1:0]         cur_word;
    logic [BEAT_CODES*CW-1:0]  dq_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
            cap   <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
            if (capture) begin
                cap <= in_data;
            end
        end
    end

    // Slots beyond the last neuron read as zero from the padded copy.
    always_comb begin
        padded           = '0;
        padded[IN_W-1:0] = cap;
    end

    for (genvar b = 0; b < NBEATS; b++) begin : g_beat
        assign beat_words[b] = padded[b*WORD_W +: WORD_W];
    end

    assign cur_word = beat_words[beat];

    for (genvar k = 0; k < BEAT_CODES; k++) begin : g_slot
        code_dequant #(
            .OUT_BITS (OUT_BITS),
            .SCALE    (SCALE),
            .DQ_W     (DQ_W),
            .CW       (CW)
        ) u_code_dequant (
            .code  (cur_word[k*OUT_BITS +: OUT_BITS]),
            .value (dq_word[k*CW +: CW])
        );
    end

    assign m_data = (state == SEND) ? dq_word : '0;

    always_comb begin
        state_n  = state;
        beat_n   = beat;
        capture  = 1'b0;
        in_ready = 1'b0;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    beat_n  = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                m_last  = (beat == LAST_BEAT);
                if (m_ready) begin
                    if (beat == LAST_BEAT) begin
                        // Accepting the next vector here keeps the stream bubble-free.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            capture = 1'b1;
                            beat_n  = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_layer_output_serializer.sv
// tb/tb_layer_output_serializer.sv - randomized self-checking bench for layer_output_serializer
// Reference model follows LAYER_OUTPUT_SERIALIZER_DEQUANT_EN.
module tb_layer_output_serializer;
    import layer_output_serializer_pkg::*;

    localparam int OB = 2;
    localparam int BC = 4;
    localparam int SC = 3;
    localparam int DQ = 8;
    localparam int CW = code_width(OB, DQ);
    localparam int N0 = 16;
    localparam int N1 = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 v0, r0, mv0, mr0, ml0;
    logic [N0*OB-1:0]     d0;
    logic [BC*CW-1:0]     md0;
    logic                 v1, r1, mv1, mr1, ml1;
    logic [N1*OB-1:0]     d1;
    logic [BC*CW-1:0]     md1;

    layer_output_serializer #(
        .NUM_NEURONS(N0), .OUT_BITS(OB), .BEAT_CODES(BC), .SCALE(SC), .DQ_W(DQ)
    ) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
        .m_valid(mv0), .m_ready(mr0), .m_data(md0), .m_last(ml0)
    );

    layer_output_serializer #(
        .NUM_NEURONS(N1), .OUT_BITS(OB), .BEAT_CODES(BC), .SCALE(SC), .DQ_W(DQ)
    ) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
        .m_valid(mv1), .m_ready(mr1), .m_data(md1), .m_last(ml1)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit armed = 1'b0;
    int acc0 = 0;

    // Each expected beat: {last, data}
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dq_code(input int code);
`ifdef LAYER_OUTPUT_SERIALIZER_DEQUANT_EN
        return (code * SC) % (1 << DQ);
`else
        return code;
`endif
    endfunction

    function automatic void push_vec(input int id, input logic [31:0] vec, input int n);
        int nb;
        nb = (n + BC - 1) / BC;
        for (int b = 0; b < nb; b++) begin
            logic [32:0] e;
            e = '0;
            for (int k = 0; k < BC; k++) begin
                int idx;
                int code;
                idx  = b * BC + k;
                code = (idx < n) ? int'((vec >> (idx * OB)) & ((1 << OB) - 1)) : 0;
                e[31:0] = e[31:0] | (32'(dq_code(code)) << (k * CW));
            end
            e[32] = (b == nb - 1);
            if (id == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            bit exp_rdy;
            logic [32:0] e;
            exp_rdy = (q0.size() == 0) || (q0.size() == 1 && mr0);
            check("m_valid0", 64'(mv0), 64'(q0.size() > 0));
            check("in_ready0", 64'(r0), 64'(exp_rdy));
            if (q0.size() > 0) begin
                e = q0[0];
                check("m_data0", 64'(md0), 64'(e[31:0]));
                check("m_last0", 64'(ml0), 64'(e[32]));
                if (mr0) void'(q0.pop_front());
            end
            if (v0 && exp_rdy) begin
                push_vec(0, 32'(d0), N0);
                acc0++;
            end
            if (rst) q0.delete();
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            bit exp_rdy;
            logic [32:0] e;
            exp_rdy = (q1.size() == 0) || (q1.size() == 1 && mr1);
            check("m_valid1", 64'(mv1), 64'(q1.size() > 0));
            check("in_ready1", 64'(r1), 64'(exp_rdy));
            if (q1.size() > 0) begin
                e = q1[0];
                check("m_data1", 64'(md1), 64'(e[31:0]));
                check("m_last1", 64'(ml1), 64'(e[32]));
                if (mr1) void'(q1.pop_front());
            end
            if (v1 && exp_rdy) push_vec(1, 32'(d1), N1);
            if (rst) q1.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        v0 = 1'b0;
        v1 = 1'b0;
        mr0 = 1'b1;
        mr1 = 1'b1;
        for (int i = 0; i < 200 && (q0.size() + q1.size()) != 0; i++) step();
        check("drain", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    initial begin
        int target;
        int pat [4] = '{1, 0, 0, 1};
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0; mr0 = 1'b1; mr1 = 1'b1;
        d0 = '0; d1 = '0;
        step();
        step();
        check("rst_m_valid", 64'(mv0), 64'd0);
        check("rst_in_ready", 64'(r0), 64'd1);
        check("rst_m_data", 64'(md0), 64'd0);
        check("rst_m_last", 64'(ml0), 64'd0);
        rst = 1'b0;
        armed = 1'b1;
        repeat (4) step();

        // Single vector, free-flowing sink
        v0 = 1'b1; d0 = 32'hE4E4_1B1B;
        step();
        v0 = 1'b0;
        drain();

        // Backpressure pattern 1,0,0,1
        v0 = 1'b1; d0 = 32'hE4E4_1B1B;
        step();
        v0 = 1'b0;
        for (int i = 0; i < 100 && q0.size() != 0; i++) begin
            mr0 = pat[i % 4][0];
            step();
        end
        drain();

        // Back-to-back vectors with in_valid held
        target = acc0 + 2;
        v0 = 1'b1; d0 = 32'hE4E4_1B1B;
        step();
        d0 = 32'hFFFF_0000;
        for (int i = 0; i < 20 && acc0 < target; i++) step();
        check("b2b_accepted", 64'(acc0), 64'(target));
        drain();

        // Partial last beat on the 10-neuron instance
        v1 = 1'b1; d1 = 20'hFFFFF;
        step();
        v1 = 1'b0;
        drain();

        // Randomized traffic on both instances
        for (int i = 0; i < 600; i++) begin
            v0 = 1'($urandom % 2);
            d0 = 32'($urandom);
            mr0 = ($urandom % 4) != 0;
            v1 = 1'($urandom % 2);
            d1 = 20'($urandom);
            mr1 = ($urandom % 3) != 0;
            step();
        end
        drain();

        // Reset in the middle of a stalled vector
        mr0 = 1'b0;
        v0 = 1'b1; d0 = 32'($urandom);
        step();
        v0 = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_m_valid", 64'(mv0), 64'd0);
        check("midrst_in_ready", 64'(r0), 64'd1);
        check("midrst_m_data", 64'(md0), 64'd0);
        rst = 1'b0;
        mr0 = 1'b1;
        repeat (3) step();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
